// File: rtl/sort_drain.sv
// sort_drain: read-out end of the bubble-sort engine.
// After the sorter's done pulse, reads cnt = min(N, 2**ADDR_W) words from the
// sorter RAM (1-cycle read latency) and streams them in address order on a
// valid/ready port, flagging the last beat.
// Optional feature macro: SORT_DRAIN_ORDER_CHECK_EN (sticky descending-pair
// flag on Order_Err). When it is undefined, Order_Err is tied to 0.
module sort_drain #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int N_W    = 6
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Done,
  input  logic [N_W-1:0]    N,
  output logic              Mem_Rd,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic [DATA_W-1:0] Mem_Data,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Out_Last,
  output logic              Busy,
  output logic              Drain_Done,
  output logic              Order_Err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, RD, CAP, HOLD, FIN} state_t;

  // Saturate the requested element count to the RAM depth.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [N_W-1:0] n);
    if (32'(n) > 32'(DEPTH))
      return CNT_W'(DEPTH);
    else
      return CNT_W'(n);
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_req;
  logic              is_last;
  logic              mem_rd;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              drain_done;

  assign cnt_req = sat_cnt(N);
  // cnt is never 0 outside IDLE/FIN, so cnt-1 cannot underflow where used.
  assign is_last = ({1'b0, idx} == (cnt - 1'b1));

  // Drain FSM: one RAM read, one capture, then hold the beat until accepted.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      mem_rd     <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      mem_rd     <= 1'b0;
      drain_done <= 1'b0;
      case (state)
        IDLE: begin
          if (Done) begin
            cnt <= cnt_req;
            idx <= '0;
            if (cnt_req == '0) begin
              state      <= FIN;
              drain_done <= 1'b1;
            end else begin
              state  <= RD;
              mem_rd <= 1'b1;
            end
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          out_data  <= Mem_Data;
          out_valid <= 1'b1;
          out_last  <= is_last;
          state     <= HOLD;
        end
        HOLD: begin
          if (Out_Ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state      <= FIN;
              drain_done <= 1'b1;
            end else begin
              idx    <= idx + 1'b1;
              mem_rd <= 1'b1;
              state  <= RD;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign Mem_Rd     = mem_rd;
  assign Mem_Addr   = idx;
  assign Out_Data   = out_data;
  assign Out_Valid  = out_valid;
  assign Out_Last   = out_last;
  assign Busy       = (state != IDLE);
  assign Drain_Done = drain_done;

`ifdef SORT_DRAIN_ORDER_CHECK_EN
  // True when the current beat is smaller than the previous one (unsigned).
  function automatic logic is_descending(input logic [DATA_W-1:0] cur,
                                         input logic [DATA_W-1:0] prev);
    return (cur < prev);
  endfunction

  logic [DATA_W-1:0] prev_data;
  logic              have_prev;
  logic              order_err;

  // Compare each accepted beat with the previous beat of the same drain.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      have_prev <= 1'b0;
      order_err <= 1'b0;
    end else if (state == IDLE && Done) begin
      have_prev <= 1'b0;
      order_err <= 1'b0;
    end else if (state == HOLD && Out_Ready) begin
      if (have_prev && is_descending(out_data, prev_data))
        order_err <= 1'b1;
      prev_data <= out_data;
      have_prev <= 1'b1;
    end
  end

  assign Order_Err = order_err;
`else
  assign Order_Err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_drain.sv
// Directed testbench for sort_drain with a behavioural 1-cycle-latency RAM.
module tb_sort_drain;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int N_W    = 6;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              Done = 1'b0;
  logic [N_W-1:0]    N = '0;
  logic              Mem_Rd;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Data = '0;
  logic [DATA_W-1:0] Out_Data;
  logic              Out_Valid;
  logic              Out_Ready = 1'b0;
  logic              Out_Last;
  logic              Busy;
  logic              Drain_Done;
  logic              Order_Err;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [0:31];

  sort_drain #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_W(N_W)) dut (
    .Clk(Clk), .Rst(Rst), .Done(Done), .N(N),
    .Mem_Rd(Mem_Rd), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data),
    .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Last(Out_Last), .Busy(Busy), .Drain_Done(Drain_Done),
    .Order_Err(Order_Err)
  );

  always #5 Clk = ~Clk;

  // Synchronous RAM model
  always @(posedge Clk) if (Mem_Rd) Mem_Data <= mem[Mem_Addr];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor, sampled on the falling edge
  logic [DATA_W-1:0] beats[$];
  logic              lasts[$];
  logic              errs[$];
  int                acc_cyc[$];
  logic [ADDR_W-1:0] rd_addr[$];
  int dd_n = 0, dd_cyc = 0, busy_n = 0, vld_n = 0;

  always @(negedge Clk) begin
    if (Out_Valid && Out_Ready) begin
      beats.push_back(Out_Data);
      lasts.push_back(Out_Last);
      errs.push_back(Order_Err);
      acc_cyc.push_back(cyc);
    end
    if (Drain_Done) begin dd_n++; dd_cyc = cyc; end
    if (Mem_Rd) rd_addr.push_back(Mem_Addr);
    if (Busy) busy_n++;
    if (Out_Valid) vld_n++;
  end

  task automatic clear_mon();
    beats.delete(); lasts.delete(); errs.delete(); acc_cyc.delete(); rd_addr.delete();
    dd_n = 0; dd_cyc = 0; busy_n = 0; vld_n = 0;
  endtask

  task automatic pulse_done(input int n);
    @(posedge Clk); #1;
    N = N_W'(n); Done = 1'b1;
    @(posedge Clk); #1;
    Done = 1'b0;
  endtask

  task automatic wait_drain(input int target, input int budget);
    int k = 0;
    while (dd_n < target && k < budget) begin @(posedge Clk); #1; k++; end
    if (dd_n < target) begin
      checks++; errors++;
      $display("FAIL wait_drain: timeout, drain pulses %0d, required %0d", dd_n, target);
    end
    repeat (3) begin @(posedge Clk); #1; end
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!Out_Valid && k < budget) begin @(posedge Clk); #1; k++; end
    if (!Out_Valid) begin
      checks++; errors++;
      $display("FAIL wait_valid: timeout, Out_Valid=%0b, required 1", Out_Valid);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; Done = 1'b1; N = 6'd4;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({Mem_Rd, Mem_Addr, Out_Data, Out_Valid, Out_Last, Busy, Drain_Done, Order_Err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%0b addr=%0d data=%0d vld=%0b last=%0b busy=%0b dd=%0b oe=%0b, required all 0",
               Mem_Rd, Mem_Addr, Out_Data, Out_Valid, Out_Last, Busy, Drain_Done, Order_Err);
    end
    Rst = 1'b0; Done = 1'b0; N = '0;
    @(posedge Clk); #1;
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] exp [4] = '{8'd3, 8'd7, 8'd9, 8'd200};
    mem[0] = 8'd3; mem[1] = 8'd7; mem[2] = 8'd9; mem[3] = 8'd200;
    clear_mon(); Out_Ready = 1'b1;
    pulse_done(4);
    checks++;
    if (!(Mem_Rd === 1'b1 && Mem_Addr === 5'd0 && Busy === 1'b1)) begin
      errors++;
      $display("FAIL basic_e0: rd=%0b addr=%0d busy=%0b, required 1 0 1", Mem_Rd, Mem_Addr, Busy);
    end
    @(posedge Clk); #1;
    checks++;
    if (!(Mem_Rd === 1'b0 && Out_Valid === 1'b0)) begin
      errors++;
      $display("FAIL basic_e1: rd=%0b vld=%0b, required 0 0", Mem_Rd, Out_Valid);
    end
    @(posedge Clk); #1;
    checks++;
    if (!(Out_Valid === 1'b1 && Out_Data === 8'd3)) begin
      errors++;
      $display("FAIL basic_e2: vld=%0b data=%0d, required 1 3", Out_Valid, Out_Data);
    end
    wait_drain(1, 40);
    checks++;
    if (beats.size() != 4) begin
      errors++;
      $display("FAIL basic_count: beats %0d, required 4", beats.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (beats[i] !== exp[i] || lasts[i] !== (i == 3)) begin
          errors++;
          $display("FAIL basic_beat%0d: data=%0d last=%0b, required %0d %0b", i, beats[i], lasts[i], exp[i], (i == 3));
        end
      end
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != 3) begin
        errors++;
        $display("FAIL basic_rate: beat spacing %0d, required 3", acc_cyc[1] - acc_cyc[0]);
      end
      checks++;
      if (dd_n != 1 || dd_cyc != acc_cyc[3] + 1) begin
        errors++;
        $display("FAIL basic_drain_done: pulses %0d at %0d, required 1 at %0d", dd_n, dd_cyc, acc_cyc[3] + 1);
      end
    end
    checks++;
    if (Order_Err !== 1'b0) begin
      errors++;
      $display("FAIL basic_order_err: %0b, required 0", Order_Err);
    end
  endtask

  task automatic test_zero();
    clear_mon(); Out_Ready = 1'b1;
    pulse_done(0);
    wait_drain(1, 10);
    checks++;
    if (!(vld_n == 0 && rd_addr.size() == 0 && busy_n == 1 && dd_n == 1)) begin
      errors++;
      $display("FAIL zero_count: vld=%0d rd=%0d busy=%0d dd=%0d, required 0 0 1 1",
               vld_n, rd_addr.size(), busy_n, dd_n);
    end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    clear_mon(); Out_Ready = 1'b1;
    pulse_done(40);
    wait_drain(1, 200);
    checks++;
    if (beats.size() != 32 || rd_addr.size() != 32) begin
      errors++;
      $display("FAIL clamp_count: beats %0d reads %0d, required 32 32", beats.size(), rd_addr.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (beats[i] !== 8'(i) || rd_addr[i] !== 5'(i) || lasts[i] !== (i == 31)) begin
          errors++;
          $display("FAIL clamp_beat%0d: data=%0d addr=%0d last=%0b, required %0d %0d %0b",
                   i, beats[i], rd_addr[i], lasts[i], i, i, (i == 31));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] exp [3] = '{8'd10, 8'd20, 8'd30};
    logic [DATA_W-1:0] held;
    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30;
    clear_mon(); Out_Ready = 1'b0;
    pulse_done(3);
    for (int b = 0; b < 3; b++) begin
      wait_valid(20);
      if (b == 1) begin
        held = Out_Data;
        for (int k = 0; k < 5; k++) begin
          Done = (k == 0);
          N = 6'd3;
          @(posedge Clk); #1;
          checks++;
          if (!(Out_Valid === 1'b1 && Out_Data === held && Out_Last === 1'b0)) begin
            errors++;
            $display("FAIL stall_hold%0d: vld=%0b data=%0d last=%0b, required 1 %0d 0",
                     k, Out_Valid, Out_Data, Out_Last, held);
          end
        end
        Done = 1'b0;
      end
      Out_Ready = 1'b1;
      @(posedge Clk); #1;
      Out_Ready = 1'b0;
    end
    wait_drain(1, 20);
    repeat (10) begin @(posedge Clk); #1; end
    checks++;
    if (beats.size() != 3 || rd_addr.size() != 3 || dd_n != 1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_count: beats %0d reads %0d dd %0d busy %0b, required 3 3 1 0",
               beats.size(), rd_addr.size(), dd_n, Busy);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (beats[i] !== exp[i]) begin
          errors++;
          $display("FAIL stall_beat%0d: data=%0d, required %0d", i, beats[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
    clear_mon(); Out_Ready = 1'b0;
    pulse_done(4);
    wait_valid(20);
    Out_Ready = 1'b1;
    @(posedge Clk); #1;
    Out_Ready = 1'b0;
    wait_valid(20);
    Rst = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if ({Mem_Rd, Mem_Addr, Out_Data, Out_Valid, Out_Last, Busy, Drain_Done, Order_Err} !== '0) begin
      errors++;
      $display("FAIL resetmid_outputs: rd=%0b addr=%0d data=%0d vld=%0b last=%0b busy=%0b dd=%0b oe=%0b, required all 0",
               Mem_Rd, Mem_Addr, Out_Data, Out_Valid, Out_Last, Busy, Drain_Done, Order_Err);
    end
    Rst = 1'b0;
    repeat (5) begin @(posedge Clk); #1; end
    checks++;
    if (dd_n != 0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL resetmid_no_done: dd %0d busy %0b, required 0 0", dd_n, Busy);
    end
    clear_mon(); Out_Ready = 1'b1;
    pulse_done(4);
    wait_drain(1, 40);
    checks++;
    if (beats.size() != 4 || rd_addr.size() != 4) begin
      errors++;
      $display("FAIL resetmid_restart: beats %0d reads %0d, required 4 4", beats.size(), rd_addr.size());
    end else begin
      checks++;
      if (rd_addr[0] !== 5'd0 || beats[0] !== 8'd1 || beats[3] !== 8'd4) begin
        errors++;
        $display("FAIL resetmid_order: addr0=%0d b0=%0d b3=%0d, required 0 1 4", rd_addr[0], beats[0], beats[3]);
      end
    end
  endtask

  task automatic test_order();
    logic exp_final;
`ifdef SORT_DRAIN_ORDER_CHECK_EN
    exp_final = 1'b1;
`else
    exp_final = 1'b0;
`endif
    mem[0] = 8'd5; mem[1] = 8'd9; mem[2] = 8'd4;
    clear_mon(); Out_Ready = 1'b1;
    pulse_done(3);
    wait_drain(1, 30);
    checks++;
    if (errs.size() != 3) begin
      errors++;
      $display("FAIL order_count: beats %0d, required 3", errs.size());
    end else begin
      checks++;
      if (errs[1] !== 1'b0 || errs[2] !== 1'b0) begin
        errors++;
        $display("FAIL order_early: err before beat2=%0b before beat3=%0b, required 0 0", errs[1], errs[2]);
      end
    end
    repeat (5) begin @(posedge Clk); #1; end
    checks++;
    if (Order_Err !== exp_final) begin
      errors++;
      $display("FAIL order_sticky: Order_Err=%0b, required %0b", Order_Err, exp_final);
    end
    clear_mon();
    pulse_done(0);
    checks++;
    if (Order_Err !== 1'b0) begin
      errors++;
      $display("FAIL order_clear: Order_Err=%0b, required 0", Order_Err);
    end
    wait_drain(1, 10);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_zero();
    test_clamp();
    test_stall();
    test_reset_mid();
    test_order();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
